// File: rtl/hazard_scoreboard.sv
// Forwarding selects plus load-use / MDU stall control for the ID stage.
// fwd_sel and stall are combinational from the current stage tags; counters update on the clock edge.
module hazard_scoreboard #(
    parameter int RA_W     = 5,
    parameter int NRP      = 2,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRP*RA_W-1:0]   id_ra,
    input  logic [NRP-1:0]        id_re,
    input  logic                  id_hilo,
    input  logic                  exe_wrf,
    input  logic [RA_W-1:0]       exe_wa,
    input  logic                  exe_load,
    input  logic                  exe_alu,
    input  logic                  mdu_start,
    input  logic                  mem_wrf,
    input  logic [RA_W-1:0]       mem_wa,
    input  logic                  mem_load,
    input  logic                  flush,
    output logic [NRP*2-1:0]      fwd_sel,
    output logic                  stall,
    output logic                  bubble,
    output logic                  mdu_busy,
    output logic [31:0]           stall_cnt
);

    localparam int LD_CW  = 3;
    localparam int MDU_CW = 6;

    typedef enum logic {RUN, LD_WAIT} state_t;

    state_t              state_q;
    logic [LD_CW-1:0]    ld_cnt_q;
    logic [MDU_CW-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;

    logic [NRP-1:0]      ld_match;
    logic                ldhaz;
    logic                mduhaz;

    for (genvar k = 0; k < NRP; k++) begin : g_port
        logic [RA_W-1:0] ra;
        logic            en;
        logic            hit_exe, hit_mem_alu, hit_mem_ld;
        logic [1:0]      sel;

        assign ra          = id_ra[k*RA_W +: RA_W];
        assign en          = id_re[k] && (ra != '0);
        assign hit_exe     = en && exe_wrf && exe_alu && !exe_load && (exe_wa == ra);
        assign hit_mem_alu = en && mem_wrf && !mem_load && (mem_wa == ra);
        assign hit_mem_ld  = en && mem_wrf && mem_load && (mem_wa == ra);
        assign ld_match[k] = en && (exe_wa == ra);

        // EXE is the younger producer, so it wins over MEM
        always_comb begin
            sel = 2'b00;
            if (hit_exe)          sel = 2'b01;
            else if (hit_mem_alu) sel = 2'b10;
            else if (hit_mem_ld)  sel = 2'b11;
        end

        assign fwd_sel[2*k +: 2] = sel;
    end

    assign ldhaz    = exe_wrf && exe_load && (exe_wa != '0) && (|ld_match);
    assign mdu_busy = (mdu_cnt_q != '0);
    assign mduhaz   = id_hilo && (mdu_busy || mdu_start);

    // Gated by rst so a held hazard input cannot leak a stall through reset
    assign stall     = !rst && ((state_q == LD_WAIT) || ldhaz || mduhaz);
    assign bubble    = stall;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (mdu_start)
            mdu_cnt_d = MDU_CW'(MDU_LAT);
        else if (mdu_cnt_q != '0)
            mdu_cnt_d = mdu_cnt_q - 1'b1;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            ld_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ldhaz && !flush && (LOAD_LAT > 1)) begin
                        state_q  <= LD_WAIT;
                        ld_cnt_q <= LD_CW'(LOAD_LAT - 1);
                    end
                end
                LD_WAIT: begin
                    // A flush discards the stalled consumer, so the wait is moot
                    if (flush) begin
                        state_q  <= RUN;
                        ld_cnt_q <= '0;
                    end else begin
                        ld_cnt_q <= ld_cnt_q - 1'b1;
                        if (ld_cnt_q == LD_CW'(1))
                            state_q <= RUN;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    ld_cnt_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: driver queues expected outputs, a negedge monitor checks them.
module tb_hazard_scoreboard;

    localparam int RA_W = 5;
    localparam int NRP  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NRP*RA_W-1:0]  id_ra;
    logic [NRP-1:0]       id_re;
    logic                 id_hilo, exe_wrf, exe_load, exe_alu, mdu_start;
    logic                 mem_wrf, mem_load, flush;
    logic [RA_W-1:0]      exe_wa, mem_wa;
    logic [NRP*2-1:0]     fwd_sel;
    logic                 stall, bubble, mdu_busy;
    logic [31:0]          stall_cnt;

    hazard_scoreboard #(.RA_W(RA_W), .NRP(NRP), .LOAD_LAT(3), .MDU_LAT(4)) dut (
        .clk(clk), .rst(rst), .id_ra(id_ra), .id_re(id_re), .id_hilo(id_hilo),
        .exe_wrf(exe_wrf), .exe_wa(exe_wa), .exe_load(exe_load), .exe_alu(exe_alu),
        .mdu_start(mdu_start), .mem_wrf(mem_wrf), .mem_wa(mem_wa), .mem_load(mem_load),
        .flush(flush), .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [3:0]  fwd;
        logic        st;
        logic        busy;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.nm, ".fwd_sel"},   32'(fwd_sel),   32'(e.fwd));
                chk({e.nm, ".stall"},     32'(stall),     32'(e.st));
                chk({e.nm, ".bubble"},    32'(bubble),    32'(e.st));
                chk({e.nm, ".mdu_busy"},  32'(mdu_busy),  32'(e.busy));
                chk({e.nm, ".stall_cnt"}, stall_cnt,      e.sc);
            end
        end
    end

    // Queue the expectation for the inputs now applied, then advance one cycle
    task automatic cyc(input string nm, input logic [3:0] f, input logic s,
                       input logic b, input logic [31:0] c);
        exp_t e;
        e.nm = nm; e.fwd = f; e.st = s; e.busy = b; e.sc = c;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_ra = '0; id_re = '0; id_hilo = 0; exe_wrf = 0; exe_wa = '0;
        exe_load = 0; exe_alu = 0; mdu_start = 0; mem_wrf = 0; mem_wa = '0;
        mem_load = 0; flush = 0;
    endtask

    task automatic ld_exe5();
        exe_wrf = 1; exe_load = 1; exe_alu = 0; exe_wa = 5'd5;
        mem_wrf = 0; mem_load = 0; mem_wa = '0;
        id_ra = {5'd5, 5'd0}; id_re = 2'b10;
    endtask

    task automatic ld_mem5();
        exe_wrf = 0; exe_load = 0; exe_alu = 0; exe_wa = '0;
        mem_wrf = 1; mem_load = 1; mem_wa = 5'd5;
        id_ra = {5'd5, 5'd0}; id_re = 2'b10;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : driver
        clr();
        @(posedge clk);
        #1;
        cyc("reset", 4'b0000, 0, 0, 0);
        rst = 0;

        // ALU forwarding and priority
        clr(); id_ra = {5'd0, 5'd3}; id_re = 2'b01; exe_wrf = 1; exe_alu = 1; exe_wa = 5'd3;
        cyc("t1_exe", 4'b0001, 0, 0, 0);
        id_ra = {5'd3, 5'd3}; id_re = 2'b11;
        cyc("t1_both", 4'b0101, 0, 0, 0);
        id_ra = {5'd0, 5'd3}; id_re = 2'b01; mem_wrf = 1; mem_load = 1; mem_wa = 5'd3;
        cyc("t2_prio", 4'b0001, 0, 0, 0);
        exe_wrf = 0;
        cyc("t2_memld", 4'b0011, 0, 0, 0);
        mem_load = 0;
        cyc("t2_memalu", 4'b0010, 0, 0, 0);
        id_re = 2'b00;
        cyc("t2_noren", 4'b0000, 0, 0, 0);
        clr(); id_re = 2'b11; exe_wrf = 1; exe_alu = 1; mem_wrf = 1;
        cyc("t2_r0", 4'b0000, 0, 0, 0);
        exe_alu = 0; exe_load = 1;
        cyc("t2_r0ld", 4'b0000, 0, 0, 0);

        // Three-cycle load-use stall
        clr(); ld_exe5();
        cyc("t3_c0", 4'b0000, 1, 0, 0);
        ld_mem5();
        cyc("t3_c1", 4'b1100, 1, 0, 1);
        cyc("t3_c2", 4'b1100, 1, 0, 2);
        cyc("t3_rel", 4'b1100, 0, 0, 3);

        // Flush during the load wait
        clr(); ld_exe5();
        cyc("t4_c0", 4'b0000, 1, 0, 3);
        ld_mem5(); flush = 1;
        cyc("t4_flush", 4'b1100, 1, 0, 4);
        clr();
        cyc("t4_after", 4'b0000, 0, 0, 5);
        cyc("t4_idle", 4'b0000, 0, 0, 5);

        // MDU window
        mdu_start = 1;
        cyc("t5_start", 4'b0000, 0, 0, 5);
        mdu_start = 0; id_hilo = 1;
        cyc("t5_w1", 4'b0000, 1, 1, 5);
        cyc("t5_w2", 4'b0000, 1, 1, 6);
        cyc("t5_w3", 4'b0000, 1, 1, 7);
        cyc("t5_w4", 4'b0000, 1, 1, 8);
        cyc("t5_done", 4'b0000, 0, 0, 9);
        id_hilo = 0; mdu_start = 1;
        cyc("t5_rs", 4'b0000, 0, 0, 9);
        mdu_start = 0;
        cyc("t5_r4", 4'b0000, 0, 1, 9);
        cyc("t5_r3", 4'b0000, 0, 1, 9);
        mdu_start = 1;
        cyc("t5_reload", 4'b0000, 0, 1, 9);
        mdu_start = 0;
        for (int i = 0; i < 4; i++)
            cyc($sformatf("t5_rl%0d", i), 4'b0000, 0, 1, 9);
        cyc("t5_rlend", 4'b0000, 0, 0, 9);

        // Load-use and MDU hazards overlapping
        clr(); ld_exe5(); mdu_start = 1; id_hilo = 1;
        cyc("both_c0", 4'b0000, 1, 0, 9);
        ld_mem5(); mdu_start = 0;
        cyc("both_c1", 4'b1100, 1, 1, 10);
        cyc("both_c2", 4'b1100, 1, 1, 11);
        cyc("both_c3", 4'b1100, 1, 1, 12);
        cyc("both_c4", 4'b1100, 1, 1, 13);
        cyc("both_end", 4'b1100, 0, 0, 14);

        // Reset in the middle of both windows
        clr(); ld_exe5(); mdu_start = 1;
        cyc("t6_c0", 4'b0000, 1, 0, 14);
        ld_mem5(); mdu_start = 0; id_hilo = 1;
        cyc("t6_c1", 4'b1100, 1, 1, 15);
        rst = 1;
        cyc("t6_rst", 4'b1100, 0, 0, 0);
        rst = 0; clr();
        cyc("t6_post", 4'b0000, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
